alu_decode_issue: RTL
=====================

# alu_decode_issue

- ID-stage block that decodes a 32-bit MIPS instruction into the ALU-control inputs: ALUop, func, operand selects and extended immediate.
- Registers the decoded fields into an ID/EX pipeline register with stall, flush, bubble insertion and an issue counter.
- Outputs feed the EX-stage ALU_control/ALU pair directly.

## Interface
Parameters:
- CNT_W, 16, width of issued-instruction counter

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_instr  in  32  instruction word from IF/ID
- i_valid  in  1  i_instr is a real instruction
- i_stall  in  1  hold the ID/EX register
- i_flush  in  1  replace next ID/EX contents with bubble
- o_ready  out  1  combinational, equals !i_stall
- o_valid  out  1  registered ID/EX contents are a live instruction
- o_ALUop  out  4  to ALU_control is_ALUop
- o_func  out  6  to ALU_control i_func
- o_shamt_sel  out  1  ALU operand A = zero-extended instr[10:6]
- o_shamt  out  5  instr[10:6]
- o_imm_sel  out  1  ALU operand B = o_imm
- o_imm  out  32  extended instr[15:0]
- o_illegal  out  1  sticky illegal-opcode flag (macro-gated)
- o_issue_cnt  out  CNT_W  live instructions issued, wraps

## Operation
Opcode instr[31:26] -> ALUop, imm extension, imm_sel:
- 000000 R-type -> 0000, func = instr[5:0], imm_sel=0
- loads 100000/100001/100011/100100/100101, stores 101000/101001/101011 -> 0001, sign-ext, imm_sel=1
- ADDI 001000, ADDIU 001001 -> 0010, sign-ext
- ANDI 001100 -> 0011, zero-ext
- ORI 001101 -> 0100, zero-ext
- XORI 001110 -> 0101, zero-ext
- SLTI 001010 -> 0110, sign-ext
- any other opcode -> illegal, ALUop 1111

Field rules:
- Non-R-type: func = 6'b111111.
- shamt_sel = 1 only for R-type with func 000000, 000010 or 000011 (SLL/SRL/SRA). It is 0 for variable shifts.
- imm_sel = 0 for R-type; o_imm is still driven with the sign-extended value.

Register update per rising edge, in priority order:
1. i_flush=1: load bubble. Applies even while i_stall=1.
2. i_stall=1: hold all registered outputs and the counter.
3. Otherwise: load the decode of i_instr, with o_valid = i_valid.

Bubble and reset values:
- o_valid=0, o_ALUop=0000, o_func=000000, all selects, o_shamt and o_imm 0.
- o_issue_cnt=0, o_illegal=0.

Counter:
- o_issue_cnt increments when a live instruction is loaded (case 3, i_valid=1, and not trapped).
- Wraps from all-ones to 0.

## Timing
- Decode-to-output latency: 1 cycle; outputs change only after a clock edge.
- o_ready is the only combinational output.
- Stall is a pure hold. The producer keeps i_instr stable while o_ready=0; nothing is lost or duplicated.
- Flush and stall in the same cycle: flush wins, and the bubble persists through the remaining stall cycles.
- Reset asserted mid-stream: all outputs reach reset values immediately, without waiting for i_clk. The first load happens on the first edge after deassertion.
- i_valid=0: the fields are still decoded and registered, but o_valid=0, the counter does not move and the illegal flag is not set.

## Configuration
- ILLEGAL_OPCODE_TRAP_EN defined:
  - A live illegal instruction loads a bubble instead (o_valid=0, not counted).
  - o_illegal goes 1 on that edge and stays 1 until reset.
- Not defined:
  - An illegal instruction issues with o_valid=1, ALUop 1111, func 111111, and is counted.
  - o_illegal is tied 0.

## Test plan
- Reset with i_instr=0x8C22FFFC held during reset -> o_valid=0, all outputs 0 until the first edge after release. On that edge: o_ALUop=0001, o_func=111111, o_imm=0xFFFFFFFC, o_imm_sel=1, o_issue_cnt=1.
- R-type 0x00041100 (SLL r2,r4,4) -> ALUop 0000, func 000000, shamt_sel=1, shamt=4. Then SLLV 0x00822004 -> func 000100, shamt_sel=0.
- ANDI 0x3042F0F0, ORI 0x3442FFFF, SLTI 0x2842FFFF -> ALUop 0011/0100/0110, o_imm 0x0000F0F0 / 0x0000FFFF / 0xFFFFFFFF.
- ADDI issued, then i_stall=1 for 3 cycles with i_instr changed to XORI -> outputs and counter frozen at ADDI. Assert i_flush on the 2nd stall cycle -> bubble appears next edge and persists. Release stall -> XORI issues (ALUop 0101).
- Opcode 000010 (J) with i_valid=1:
  - Macro on: bubble, o_illegal=1 and held, counter unchanged.
  - Macro off: o_valid=1, ALUop 1111, counter +1.
- Counter wrap with CNT_W=4: 16 valid R-type issues -> o_issue_cnt returns to 0. An i_valid=0 cycle in between does not count.

Source files
------------

// File: rtl/alu_decode_issue.sv
// alu_decode_issue: ID-stage decoder for 32-bit MIPS instructions.
// Decodes the opcode into ALU-control fields (ALUop, func, operand selects and
// the extended immediate). The result is registered into an ID/EX pipeline
// register that supports stall, flush/bubble insertion and an issue counter.
//
// Optional feature macro: ILLEGAL_OPCODE_TRAP_EN
//   defined     : a live illegal opcode is replaced by a bubble and sets the
//                 sticky o_illegal flag.
//   not defined : an illegal opcode issues as ALUop 1111 and o_illegal is 0.
module alu_decode_issue #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_valid,
  output logic [3:0]       o_ALUop,
  output logic [5:0]       o_func,
  output logic             o_shamt_sel,
  output logic [4:0]       o_shamt,
  output logic             o_imm_sel,
  output logic [31:0]      o_imm,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_issue_cnt
);

`ifdef ILLEGAL_OPCODE_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [5:0]       opcode_s;
  logic [31:0]      sext_s;
  logic [31:0]      zext_s;
  logic [3:0]       alu_op_s;
  logic [5:0]       func_s;
  logic             shamt_sel_s;
  logic             imm_sel_s;
  logic [31:0]      imm_s;
  logic             illegal_s;
  logic             trap_s;
  logic             load_s;
  logic             unused_s;

  logic             valid_r;
  logic [3:0]       alu_op_r;
  logic [5:0]       func_r;
  logic             shamt_sel_r;
  logic [4:0]       shamt_r;
  logic             imm_sel_r;
  logic [31:0]      imm_r;
  logic [CNT_W-1:0] cnt_r;

  assign opcode_s = i_instr[31:26];
  assign sext_s   = {{16{i_instr[15]}}, i_instr[15:0]};
  assign zext_s   = {16'h0000, i_instr[15:0]};
  // Register fields rs/rt are consumed by the register file, not by this block.
  assign unused_s = ^i_instr[25:16];

  // A live illegal opcode is only trapped when the feature is built in.
  assign trap_s = TRAP_EN & i_valid & illegal_s;
  // A normal load happens when neither flush nor stall holds the register.
  assign load_s = ~i_flush & ~i_stall;

  // Opcode decode into ALU-control fields; unknown opcodes fall to illegal.
  always_comb begin
    alu_op_s    = 4'b1111;
    func_s      = 6'b111111;
    shamt_sel_s = 1'b0;
    imm_sel_s   = 1'b0;
    imm_s       = sext_s;
    illegal_s   = 1'b1;
    case (opcode_s)
      6'b000000: begin
        alu_op_s  = 4'b0000;
        func_s    = i_instr[5:0];
        illegal_s = 1'b0;
        case (i_instr[5:0])
          6'b000000, 6'b000010, 6'b000011: shamt_sel_s = 1'b1;
          default:                         shamt_sel_s = 1'b0;
        endcase
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101011: begin
        alu_op_s  = 4'b0001;
        imm_sel_s = 1'b1;
        illegal_s = 1'b0;
      end
      6'b001000, 6'b001001: begin
        alu_op_s  = 4'b0010;
        imm_sel_s = 1'b1;
        illegal_s = 1'b0;
      end
      6'b001100: begin
        alu_op_s  = 4'b0011;
        imm_sel_s = 1'b1;
        imm_s     = zext_s;
        illegal_s = 1'b0;
      end
      6'b001101: begin
        alu_op_s  = 4'b0100;
        imm_sel_s = 1'b1;
        imm_s     = zext_s;
        illegal_s = 1'b0;
      end
      6'b001110: begin
        alu_op_s  = 4'b0101;
        imm_sel_s = 1'b1;
        imm_s     = zext_s;
        illegal_s = 1'b0;
      end
      6'b001010: begin
        alu_op_s  = 4'b0110;
        imm_sel_s = 1'b1;
        illegal_s = 1'b0;
      end
      default: begin
        alu_op_s  = 4'b1111;
        illegal_s = 1'b1;
      end
    endcase
  end

  // ID/EX register: flush beats stall, stall holds, otherwise load the decode.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_r     <= 1'b0;
      alu_op_r    <= 4'b0000;
      func_r      <= 6'b000000;
      shamt_sel_r <= 1'b0;
      shamt_r     <= 5'd0;
      imm_sel_r   <= 1'b0;
      imm_r       <= 32'h0000_0000;
      cnt_r       <= {CNT_W{1'b0}};
    end else if (i_flush || (load_s && trap_s)) begin
      valid_r     <= 1'b0;
      alu_op_r    <= 4'b0000;
      func_r      <= 6'b000000;
      shamt_sel_r <= 1'b0;
      shamt_r     <= 5'd0;
      imm_sel_r   <= 1'b0;
      imm_r       <= 32'h0000_0000;
    end else if (i_stall) begin
      valid_r     <= valid_r;
    end else begin
      valid_r     <= i_valid;
      alu_op_r    <= alu_op_s;
      func_r      <= func_s;
      shamt_sel_r <= shamt_sel_s;
      shamt_r     <= i_instr[10:6];
      imm_sel_r   <= imm_sel_s;
      imm_r       <= imm_s;
      if (i_valid) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic illegal_r;

  // Sticky trap flag: set on the edge a live illegal opcode is trapped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      illegal_r <= 1'b0;
    end else if (load_s && trap_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign o_illegal = illegal_r;
`else
  assign o_illegal = 1'b0;
`endif

  assign o_ready     = ~i_stall;
  assign o_valid     = valid_r;
  assign o_ALUop     = alu_op_r;
  assign o_func      = func_r;
  assign o_shamt_sel = shamt_sel_r;
  assign o_shamt     = shamt_r;
  assign o_imm_sel   = imm_sel_r;
  assign o_imm       = imm_r;
  assign o_issue_cnt = cnt_r;

endmodule
